// File: rtl/img_rx_loader.sv
// Image receive stage: streams nrows*ncols host bytes from din into the image
// buffer through a registered write port, row-major from address 0.
module img_rx_loader #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              abort,
    input  logic [7:0]        nrows,
    input  logic [7:0]        ncols,
    input  logic [DATA_W-1:0] din,
    output logic              busy,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              done,
    output logic              err_size
);

    // state | meaning
    // IDLE  | waiting for start; byte 0 is captured on the start edge
    // RX    | capturing bytes 1..N-1, one per clock
    typedef enum logic {IDLE, RX} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   cnt, cnt_nxt;
    logic [ADDR_W-1:0]   n_lat, n_nxt;
    logic                we_nxt, done_nxt, err_nxt;
    logic [ADDR_W-1:0]   addr_nxt;
    logic [DATA_W-1:0]   wdata_nxt;
    logic [15:0]         prod;

    assign prod = {8'd0, nrows} * {8'd0, ncols};
    assign busy = (state == RX);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            cnt       <= '0;
            n_lat     <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            done      <= 1'b0;
            err_size  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            n_lat     <= n_nxt;
            mem_we    <= we_nxt;
            mem_addr  <= addr_nxt;
            mem_wdata <= wdata_nxt;
            done      <= done_nxt;
            err_size  <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        n_nxt     = n_lat;
        we_nxt    = 1'b0;
        addr_nxt  = mem_addr;
        wdata_nxt = mem_wdata;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (prod == 16'd0) begin
                        err_nxt = 1'b1;
                    end else begin
                        we_nxt    = 1'b1;
                        addr_nxt  = '0;
                        wdata_nxt = din;
                        if (prod == 16'd1) begin
                            done_nxt = 1'b1;
                        end else begin
                            state_nxt = RX;
                            cnt_nxt   = ADDR_W'(1);
                            n_nxt     = ADDR_W'(prod);
                        end
                    end
                end
            end
            RX: begin
                // abort wins over the capture, including the final byte
                if (abort) begin
                    state_nxt = IDLE;
                end else begin
                    we_nxt    = 1'b1;
                    addr_nxt  = cnt;
                    wdata_nxt = din;
                    cnt_nxt   = cnt + ADDR_W'(1);
                    if (cnt == n_lat - ADDR_W'(1)) begin
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_img_rx_loader.sv
// Directed bench for img_rx_loader: table of transfer cases plus a
// hand-written asynchronous reset sequence.
module tb_img_rx_loader;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  nrows = 8'd0;
    logic [7:0]  ncols = 8'd0;
    logic [7:0]  din = 8'd0;
    logic        busy, mem_we, done, err_size;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;

    img_rx_loader #(.ADDR_W(16), .DATA_W(8)) dut (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort),
        .nrows(nrows), .ncols(ncols), .din(din), .busy(busy),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .done(done), .err_size(err_size)
    );

    always #5 clk = ~clk;

    typedef struct {
        int nr; int nc; int pat; int abort_at; int start_mid; int chg_mid;
        int e_wr; int e_busy; int e_done; int e_err;
    } vec_t;

    vec_t      vecs[11];
    logic [7:0] stim[256];
    int n_tests = 0;
    int n_fail  = 0;
    int wr_cnt, busy_cnt, done_cnt, err_cnt, exp_last;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Sampled on the falling edge, half a cycle away from the capture edge
    always @(negedge clk) begin
        if (mem_we) begin
            chk("write_addr_contiguous", int'(mem_addr), wr_cnt);
            chk("write_data", int'(mem_wdata), int'(stim[mem_addr[7:0]]));
            wr_cnt++;
        end
        if (busy) busy_cnt++;
        if (err_size) err_cnt++;
        if (done) begin
            done_cnt++;
            chk("done_with_last_write", (mem_we && int'(mem_addr) == exp_last) ? 1 : 0, 1);
        end
    end

    task automatic clear_counts(input int last);
        wr_cnt = 0; busy_cnt = 0; done_cnt = 0; err_cnt = 0; exp_last = last;
    endtask

    task automatic fill_stim(input int pat);
        for (int i = 0; i < 256; i++) begin
            if (pat == 0)      stim[i] = 8'(i);
            else if (pat == 1) stim[i] = 8'($urandom_range(0, 255));
            else               stim[i] = 8'hA5 ^ 8'(i);
        end
    endtask

    task automatic run_case(input vec_t v);
        int n;
        int len;
        n = v.nr * v.nc;
        fill_stim(v.pat);
        clear_counts(n - 1);
        @(posedge clk); #1;
        nrows = 8'(v.nr); ncols = 8'(v.nc); din = stim[0]; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        len = ((n > 0) ? n : 1) + 4;
        for (int j = 1; j <= len; j++) begin
            din = stim[j % 256];
            if (j == v.abort_at) abort = 1'b1;
            if (v.start_mid != 0 && j == 3) start = 1'b1;
            if (v.chg_mid != 0 && j == 2) nrows = 8'd2;
            @(posedge clk); #1;
            abort = 1'b0; start = 1'b0;
        end
        chk($sformatf("writes_%0dx%0d", v.nr, v.nc), wr_cnt, v.e_wr);
        chk($sformatf("busy_cycles_%0dx%0d", v.nr, v.nc), busy_cnt, v.e_busy);
        chk($sformatf("done_pulses_%0dx%0d", v.nr, v.nc), done_cnt, v.e_done);
        chk($sformatf("err_pulses_%0dx%0d", v.nr, v.nc), err_cnt, v.e_err);
    endtask

    initial begin
        int w0;
        //          nr  nc pat abort smid chg  wr  busy done err
        vecs[0]  = '{4,  4,  0,  0,    0,   0,  16, 15,  1,   0};
        vecs[1]  = '{16, 16, 1,  0,    0,   0,  256,255, 1,   0};
        vecs[2]  = '{1,  1,  2,  0,    0,   0,  1,  0,   1,   0};
        vecs[3]  = '{0,  8,  0,  0,    0,   0,  0,  0,   0,   1};
        vecs[4]  = '{8,  0,  0,  0,    0,   0,  0,  0,   0,   1};
        vecs[5]  = '{4,  4,  0,  5,    0,   0,  5,  5,   0,   0};
        vecs[6]  = '{4,  4,  2,  0,    0,   0,  16, 15,  1,   0};
        vecs[7]  = '{4,  4,  0,  0,    1,   0,  16, 15,  1,   0};
        vecs[8]  = '{4,  4,  2,  0,    0,   1,  16, 15,  1,   0};
        vecs[9]  = '{2,  1,  0,  0,    0,   0,  2,  1,   1,   0};
        vecs[10] = '{3,  5,  0,  14,   0,   0,  14, 14,  0,   0};

        fill_stim(0);
        clear_counts(0);
        #12;
        chk("reset_busy", int'(busy), 0);
        chk("reset_mem_we", int'(mem_we), 0);
        chk("reset_mem_addr", int'(mem_addr), 0);
        chk("reset_mem_wdata", int'(mem_wdata), 0);
        chk("reset_done_err", int'({done, err_size}), 0);
        rstn = 1'b1;

        for (int i = 0; i < 11; i++) run_case(vecs[i]);

        // asynchronous reset between edges in the middle of a transfer
        fill_stim(0);
        clear_counts(15);
        @(posedge clk); #1;
        nrows = 8'd4; ncols = 8'd4; din = stim[0]; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int j = 1; j <= 3; j++) begin
            din = stim[j];
            @(posedge clk); #1;
        end
        #2;
        rstn = 1'b0;
        #1;
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_mem_we", int'(mem_we), 0);
        chk("async_rst_mem_addr", int'(mem_addr), 0);
        w0 = wr_cnt;
        repeat (3) @(posedge clk);
        #1;
        chk("no_writes_in_reset", wr_cnt, w0);
        chk("busy_in_reset", int'(busy), 0);
        #3;
        rstn = 1'b1;
        run_case(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/img_rx_loader.md
Name: img_rx_loader

Overview:
- Image receive stage behind the img_conv_top command interface.
- After the top-level decoder sees en=1 with op=OP_IMG_RX, this block captures nrows*ncols pixel bytes from the shared 8-bit din bus, one per clock, in row-major order.
- Each byte goes through a registered write port into the image buffer that the convolution and TX stages read later.
- While receiving, it drives busy so the host keeps streaming bytes.

Parameters:
- ADDR_W, 16, image-buffer address width; must be >= 16 so 255*255 = 65025 fits.
- DATA_W, 8, pixel width.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rstn  input  1  reset; asynchronous, active-low.
- start  input  1  one-cycle decoded request (en && op==OP_IMG_RX) from the top decoder.
- abort  input  1  synchronous cancel of the transfer in progress.
- nrows  input  8  current row-count register.
- ncols  input  8  current column-count register.
- din  input  DATA_W  host byte bus.
- busy  output  1  high while bytes 1..N-1 are still expected.
- mem_we  output  1  image-buffer write enable.
- mem_addr  output  ADDR_W  write address, row-major: addr = r*ncols + c.
- mem_wdata  output  DATA_W  write data.
- done  output  1  one-cycle pulse when the transfer completes normally.
- err_size  output  1  one-cycle pulse when start is seen with nrows==0 or ncols==0.

Behaviour:
- Reset (rstn low, asynchronous): state=IDLE; busy, mem_we, done, err_size all 0; mem_addr=0; mem_wdata=0; counter=0.
- N = nrows*ncols, computed as a 16-bit unsigned product. N, nrows and ncols are latched at start; later changes to those inputs are ignored until the next start.
- States: IDLE, RX.
- IDLE, posedge k with start=1 and N>=2:
  - capture din as byte 0; cnt=1; go to RX; busy=1 after this edge.
- IDLE, start=1 and N==1:
  - capture byte 0; stay in IDLE; busy stays 0; done pulses with the single write.
- IDLE, start=1 and N==0:
  - no write; err_size=1 for one cycle; stay in IDLE.
- RX, each posedge:
  - capture din as byte cnt; cnt++.
  - When the captured byte is N-1 (posedge k+N-1): go to IDLE; busy=0 after this edge.
  - busy is high exactly N-1 cycles.
- Write port (registered, latency 1): the byte captured at posedge t appears as mem_we=1, mem_addr=its index, mem_wdata=the byte during the cycle after t.
  - Writes therefore occur after posedges k..k+N-1, at addresses 0..N-1, with no gaps.
- done=1 in the same cycle as the write of byte N-1.
- start while in RX: ignored, no restart.
- abort in RX:
  - that edge captures nothing; state=IDLE; busy=0; mem_we=0 next cycle; no done.
  - Already-written bytes stay in the buffer.
  - If abort and the last-byte capture coincide, abort wins: byte N-1 is not written and done does not pulse.
- abort in IDLE: no effect.
- rstn asserted mid-transfer: immediate return to reset values; no further writes.
- Counter never wraps: at most 65025 bytes, below 2^ADDR_W.

Test Plan:
- nrows=4, ncols=4, start with din=0x00 then 0x01..0x0F on successive edges -> busy high 15 cycles; 16 writes at addr 0..15 with wdata==addr; done coincident with addr 15; no extra mem_we.
- nrows=16, ncols=16 with random bytes -> 256 contiguous writes, buffer contents equal the stimulus array; busy falls on the edge that captures byte 255.
- nrows=1, ncols=1, start with din=0xA5 -> one write (addr 0, 0xA5); busy never high; done in the write cycle.
- nrows=0, ncols=8, start -> err_size pulses once; no mem_we, busy, or done. Repeat with nrows=8, ncols=0 -> same.
- nrows=4, ncols=4: abort after 5 bytes -> exactly 5 writes (addr 0..4), busy drops, no done. Then start again -> full 16-write transfer from addr 0. Also: start pulsed mid-RX -> ignored; changing nrows mid-RX does not change write count.
- rstn pulled low mid-transfer, asynchronous and between edges -> busy and mem_we go to 0 immediately; after release the block is idle and accepts a new start normally.
